// File: rtl/op_arbiter.sv
// Round-robin arbiter sharing one bundled-data four-phase operator between M
// clocked requesters; operands are held T cycles before the request rises.
module op_arbiter #(
    parameter logic Rpol = 1'b0,
    parameter int   N    = 1,
    parameter int   M    = 4,
    parameter int   T    = 2,
    parameter int   SYNC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   in_valid,
    output logic [M-1:0]   in_ready,
    input  logic [M*N-1:0] in_a,
    input  logic [M*N-1:0] in_b,
    output logic [M-1:0]   out_valid,
    output logic [N-1:0]   out_d,
    output logic           op_r,
    input  logic           op_a,
    output logic [N-1:0]   op_da,
    output logic [N-1:0]   op_db,
    input  logic [N-1:0]   op_d
);

    localparam int W  = $clog2(M);
    localparam int CW = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        REL,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    ptr_q, ptr_d;
    logic [W-1:0]    win_q, win_d;
    logic            op_r_q, op_r_d;
    logic [N-1:0]    da_q, da_d;
    logic [N-1:0]    db_q, db_d;
    logic [N-1:0]    out_d_q, out_d_d;
    logic [M-1:0]    out_valid_q, out_valid_d;
    logic [SYNC-1:0] sync_q;
    logic            ack_s;

    logic            win_found;
    logic [W-1:0]    win_idx;
    logic [W:0]      sum;

    // op_a is asynchronous to clk; only the last stage is ever observed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC{Rpol}};
        end else begin
            sync_q <= {sync_q[SYNC-2:0], op_a};
        end
    end

    assign ack_s = sync_q[SYNC-1];

    // First pending requester at or above the pointer, wrapping to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int unsigned i = 0; i < M; i++) begin
            sum = {1'b0, ptr_q} + (W+1)'(i);
            if (sum >= (W+1)'(M)) begin
                sum = sum - (W+1)'(M);
            end
            if (!win_found && in_valid[sum[W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = sum[W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        op_r_d      = op_r_q;
        da_d        = da_q;
        db_d        = db_q;
        out_d_d     = out_d_q;
        out_valid_d = '0;
        in_ready    = '0;

        case (state_q)
            IDLE: begin
                // Never launch while the operator is still off its idle level.
                if (!rst && (ack_s == Rpol) && win_found) begin
                    in_ready[win_idx] = 1'b1;
                    da_d    = in_a[int'(win_idx)*N +: N];
                    db_d    = in_b[int'(win_idx)*N +: N];
                    win_d   = win_idx;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(T-1)) begin
                    op_r_d  = ~Rpol;
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REQ: begin
                if (ack_s == ~Rpol) begin
                    out_d_d = op_d;
                    op_r_d  = Rpol;
                    state_d = REL;
                end
            end
            REL: begin
                if (ack_s == Rpol) begin
                    out_valid_d[win_q] = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = (win_q == W'(M-1)) ? '0 : win_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            win_q       <= '0;
            op_r_q      <= Rpol;
            da_q        <= '0;
            db_q        <= '0;
            out_d_q     <= '0;
            out_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            op_r_q      <= op_r_d;
            da_q        <= da_d;
            db_q        <= db_d;
            out_d_q     <= out_d_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign op_r      = op_r_q;
    assign op_da     = da_q;
    assign op_db     = db_q;
    assign out_d     = out_d_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_op_arbiter.sv
// Directed bench for op_arbiter: two instances (idle-low and idle-high handshake)
// each driving a behavioural AND operator with programmable acknowledge delay.
module tb_op_arbiter;

    localparam int N    = 8;
    localparam int M    = 4;
    localparam int T    = 2;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // lane0 99&0F=09, lane1 5A&FF=5A, lane2 F0&3C=30, lane3 C3&66=42
    logic [M*N-1:0] ia = {8'hC3, 8'hF0, 8'h5A, 8'h99};
    logic [M*N-1:0] ib = {8'h66, 8'h3C, 8'hFF, 8'h0F};

    logic [M-1:0] iv0, ir0, ov0;
    logic [N-1:0] od0, da0, db0, d0;
    logic         r0, a0_m, a0_in, hold0;
    int           dly0, cnt0;

    logic [M-1:0] iv1, ir1, ov1;
    logic [N-1:0] od1, da1, db1, d1;
    logic         r1, a1_m;
    int           cnt1;

    assign a0_in = hold0 ? 1'b1 : a0_m;
    assign d0    = da0 & db0;
    assign d1    = da1 & db1;

    op_arbiter #(.Rpol(1'b0), .N(N), .M(M), .T(T), .SYNC(SYNC)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_a(ia), .in_b(ib),
        .out_valid(ov0), .out_d(od0), .op_r(r0), .op_a(a0_in),
        .op_da(da0), .op_db(db0), .op_d(d0)
    );

    op_arbiter #(.Rpol(1'b1), .N(N), .M(M), .T(T), .SYNC(SYNC)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_a(ia), .in_b(ib),
        .out_valid(ov1), .out_d(od1), .op_r(r1), .op_a(a1_m),
        .op_da(da1), .op_db(db1), .op_d(d1)
    );

    // Operator: follows op_r one cycle after a change, plus dly extra cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a0_m <= 1'b0;
            cnt0 <= 0;
        end else if (r0 != a0_m) begin
            if (cnt0 >= dly0) begin
                a0_m <= r0;
                cnt0 <= 0;
            end else begin
                cnt0 <= cnt0 + 1;
            end
        end else begin
            cnt0 <= 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a1_m <= 1'b1;
            cnt1 <= 0;
        end else if (r1 != a1_m) begin
            a1_m <= r1;
            cnt1 <= 0;
        end else begin
            cnt1 <= 0;
        end
    end

    int gcyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic grant0(input logic clr, output int idx);
        bit done;
        done = 1'b0;
        idx  = -1;
        for (int t = 0; t < 400 && !done; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (ir0 != '0) begin
                done = 1'b1;
                gcyc = cyc;
                for (int k = 0; k < M; k++) if (ir0[k]) idx = k;
            end
        end
        if (done) begin
            @(posedge clk);
            #1;
            if (clr) iv0[idx] = 1'b0;
        end
    endtask

    task automatic mon0(input logic [7:0] ea, input logic [7:0] eb, output int lat,
                        output logic [3:0] v, output int rhigh, output int rises, output int bad);
        bit   done;
        logic prev;
        done  = 1'b0;
        lat   = -1;
        v     = '0;
        rhigh = 0;
        rises = 0;
        bad   = 0;
        prev  = r0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (ov0 != '0) begin
                done = 1'b1;
                lat  = cyc - gcyc;
                v    = ov0;
            end else begin
                if (da0 !== ea || db0 !== eb) bad++;
                if (r0) rhigh++;
                if (r0 && !prev) rises++;
                prev = r0;
            end
        end
    endtask

    initial begin
        int         w, lat, rh, rs, bad, g_prev, h, cnt, rlow;
        logic [3:0] v;
        bit         seen;

        iv0 = '0; iv1 = '0; hold0 = 1'b0; dly0 = 0;
        #1 rst = 1'b1;
        iv0 = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("rst_op_r0", r0, 1'b0);
        check("rst_op_r1", r1, 1'b1);
        check("rst_out_valid", ov0, 4'h0);
        check("rst_out_d", od0, 8'h00);
        check("rst_op_da", da0, 8'h00);
        check("rst_in_ready", ir0, 4'h0);
        check("rst_in_ready1", ir1, 4'h0);
        iv0 = '0;
        rst = 1'b0;

        // single request, requester 2
        iv0 = 4'b0100;
        grant0(1'b1, w);
        check("single_winner", w, 2);
        mon0(8'hF0, 8'h3C, lat, v, rh, rs, bad);
        check("single_latency", lat, 11);
        check("single_out_valid", v, 4'b0100);
        check("single_out_d", od0, 8'h30);
        check("single_op_r_cycles", rh, 4);
        check("single_op_r_rises", rs, 1);
        check("single_operand_stable", bad, 0);
        @(negedge clk);
        check("single_strobe_one_cycle", ov0, 4'b0000);
        check("single_out_d_hold", od0, 8'h30);

        // idle-high handshake instance
        iv1 = 4'b0100;
        seen = 1'b0;
        w = -1;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (ir1 != '0) begin
                seen = 1'b1;
                gcyc = cyc;
                for (int k = 0; k < M; k++) if (ir1[k]) w = k;
            end
        end
        @(posedge clk);
        #1 iv1 = '0;
        check("rpol1_winner", w, 2);
        seen = 1'b0; lat = -1; rlow = 0; v = '0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (ov1 != '0) begin
                seen = 1'b1;
                lat  = cyc - gcyc;
                v    = ov1;
            end else if (!r1) begin
                rlow++;
            end
        end
        check("rpol1_latency", lat, 11);
        check("rpol1_out_valid", v, 4'b0100);
        check("rpol1_out_d", od1, 8'h30);
        check("rpol1_op_r_low_cycles", rlow, 4);
        check("rpol1_op_r_idle", r1, 1'b1);

        // round robin from pointer 0
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        iv0 = 4'hF;
        grant0(1'b0, w);
        check("rr_grant0", w, 0);
        g_prev = gcyc;
        grant0(1'b0, w);
        check("rr_grant1", w, 1);
        check("rr_spacing", gcyc - g_prev, 12);
        grant0(1'b0, w);
        check("rr_grant2", w, 2);
        grant0(1'b0, w);
        check("rr_grant3", w, 3);
        iv0 = 4'b1001;
        grant0(1'b1, w);
        check("rr_grant4", w, 0);
        grant0(1'b1, w);
        check("rr_grant5", w, 3);
        mon0(8'hC3, 8'h66, lat, v, rh, rs, bad);
        check("rr_out_valid", v, 4'b1000);
        check("rr_out_d", od0, 8'h42);

        // slow operator, 10-cycle acknowledge in each phase
        dly0 = 9;
        iv0 = 4'b0010;
        grant0(1'b1, w);
        check("slow_winner", w, 1);
        mon0(8'h5A, 8'hFF, lat, v, rh, rs, bad);
        check("slow_latency", lat, 29);
        check("slow_out_valid", v, 4'b0010);
        check("slow_out_d", od0, 8'h5A);
        check("slow_op_r_cycles", rh, 13);
        check("slow_operand_stable", bad, 0);

        // reset while in REQ; both requests stay pending
        iv0 = 4'b0101;
        grant0(1'b0, w);
        check("abort_winner", w, 2);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (r0) seen = 1'b1;
        end
        check("abort_reached_req", seen, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_op_r_async", r0, 1'b0);
        check("abort_no_out_valid", ov0, 4'b0000);
        check("abort_no_in_ready", ir0, 4'b0000);
        dly0 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        grant0(1'b1, w);
        check("abort_regrant_first", w, 0);
        mon0(8'h99, 8'h0F, lat, v, rh, rs, bad);
        check("abort_regrant_latency", lat, 11);
        check("abort_regrant_out_valid", v, 4'b0001);
        check("abort_regrant_out_d", od0, 8'h09);
        grant0(1'b1, w);
        check("abort_regrant_second", w, 2);
        mon0(8'hF0, 8'h3C, lat, v, rh, rs, bad);
        check("abort_second_out_valid", v, 4'b0100);
        check("abort_second_out_d", od0, 8'h30);

        // quiescence guard: op_a active before the request
        hold0 = 1'b1;
        repeat (4) @(negedge clk);
        iv0 = 4'b0001;
        cnt = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (ir0 != '0) cnt++;
        end
        check("quiesce_no_ready", cnt, 0);
        hold0 = 1'b0;
        h = cyc;
        grant0(1'b1, w);
        check("quiesce_winner", w, 0);
        check("quiesce_sync_delay", gcyc - h, SYNC);
        mon0(8'h99, 8'h0F, lat, v, rh, rs, bad);
        check("quiesce_out_valid", v, 4'b0001);
        check("quiesce_out_d", od0, 8'h09);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/op_arbiter.md
# op_arbiter

Clocked round-robin arbiter that shares one bundled-data four-phase handshake operator (e.g. `a_and`) between M synchronous requesters. Each transaction registers the winning operand pair, holds it for a programmable number of cycles to meet the operator's bundling delay, and runs a full return-to-zero handshake. The acknowledge is synchronized into the clock domain, and the result is returned to the winner as a one-cycle response. The block sits at the boundary between clocked pipeline stages and the self-timed logic library.

## Interface
- `Rpol`, default 1'b0: idle (reset) level of `op_r` and `op_a`; the active level is ~Rpol.
- `N`, default 32'b1: operand/result width.
- `M`, default 4: number of requesters; must be ≥ 2.
- `T`, default 2: setup cycles between operand launch and request assertion; must be ≥ 1.
- `SYNC`, default 2: synchronizer depth on `op_a`; must be ≥ 2.

Ports:
- `clk` input 1: single clock; everything samples on the rising edge.
- `rst` input 1: asynchronous, active-high reset. The operator's `rst` must be driven from the same net.
- `in_valid` input M: request per requester; held until accepted.
- `in_ready` output M: one-hot acceptance; combinational from state and `in_valid`.
- `in_a`, `in_b` input M*N: operands; requester i occupies bits [i*N +: N].
- `out_valid` output M: one-hot, one-cycle result strobe to the original requester.
- `out_d` output N: result; holds its value between strobes.
- `op_r` output 1: request to the operator (registered).
- `op_a` input 1: acknowledge from the operator; asynchronous.
- `op_da`, `op_db` output N: registered operands to the operator.
- `op_d` input N: operator result.

## Operation
- Reset values: `op_r`=Rpol; `op_da`, `op_db`, `out_d`, `out_valid`=0; `in_ready`=0; state IDLE; round-robin pointer 0; synchronizer flops=Rpol.
- `ack_s` is `op_a` after `SYNC` flops.
- **IDLE**
  - Grants only if `ack_s`==Rpol, so it never starts while the operator is not quiescent.
  - Winner: the first set `in_valid` bit searching from the pointer upward, with wrap-around.
  - In the grant cycle, `in_ready[w]`=1, `op_da`/`op_db` load the winner's operands, the winner index is stored, and the state moves to SETUP.
- **SETUP**: counts T cycles with operands stable, then sets `op_r`=~Rpol and moves to REQ.
- **REQ**: waits for `ack_s`==~Rpol, then captures `op_d` into `out_d`, sets `op_r`=Rpol, and moves to REL.
- **REL**: waits for `ack_s`==Rpol, then moves to RESP.
- **RESP**
  - Asserts `out_valid[w]` for one cycle.
  - Sets the pointer to (w+1) mod M, wrapping from M-1 to 0.
  - Returns to IDLE.
- Only one transaction is ever in flight. Other requesters stall with `in_valid` held.
- A requester may present a new request in the same cycle as its `out_valid`; it is eligible at the next IDLE, subject to round-robin order.
- Mid-operation reset:
  - All state returns to reset values immediately; no response is issued for the aborted transaction.
  - The operator is reset by the same `rst`, so it returns to idle as well.
- If `op_a` returns to idle before `op_r` is released (protocol violation), the block stays in REQ. No timeout.
- `in_ready` is never asserted outside IDLE.

## Timing
- Grant in cycle g. `op_da`/`op_db` are valid from g+1, and `op_r` goes active at g+1+T.
- If the operator acknowledges within the cycle `op_r` rises, `ack_s` rises SYNC cycles later. The capture edge is therefore at g+1+T+SYNC, and `op_r` returns to Rpol in the next cycle.
- Minimum grant-to-`out_valid` latency is T+2·SYNC+3 cycles. It increases one-for-one with operator acknowledge delay in either phase.
- Minimum spacing between consecutive grants equals that latency plus 1 (the IDLE cycle).
- `op_d` is captured only after `ack_s` is active. The operator guarantees data-before-ack, and the synchronizer delay provides the margin.

## Test plan
- **Single request, M=4, N=8, T=2, SYNC=2, Rpol=0**: requester 2 sends a=0xF0, b=0x3C; the model acks 1 cycle after `op_r` and releases 1 cycle after it falls → `out_valid`=4'b0100, `out_d`=0x30, `op_r` high exactly one handshake, latency matches formula.
- **Round-robin**: all four `in_valid` held high → grant order 0,1,2,3,0. Then requester 3 alone plus 0 → order continues 0, 3 from pointer.
- **Slow operator**: ack delayed 10 cycles in each phase → `op_r` is held, `op_da`/`op_db` are unchanged throughout, and latency grows by 18 cycles.
- **Reset during REQ**: `rst` pulsed mid-handshake → `op_r`=0 asynchronously, no `out_valid`; the pending request is re-granted after reset, with requester 0 first if several are pending.
- **Quiescence guard**: `op_a` held active before any request → no `in_ready` until `op_a` returns to 0 and SYNC cycles elapse.
- **Rpol=1**: repeat the single-request case with inverted handshake levels → `op_r` resets to 1, pulses low, identical data results.
